// File: rtl/bomb_pkg.sv
// bomb_pkg: shared definitions for the bomb-defusal game.
// The countdown and puzzle modules compare the game_state bus against
// these encodings, so the values are fixed and must not be renumbered.
package bomb_pkg;

  typedef enum logic [7:0] {
    ST_IDLE     = 8'h00,
    ST_ARMED    = 8'h10,
    ST_DEFUSED  = 8'h20,
    ST_EXPLODED = 8'h30
  } game_state_e;

  // Cycles the timeout check stays masked after arming. The countdown
  // reloads to 200 only after it has seen ARMED, so its digits may still
  // read 000 at the start of the round.
  localparam logic [1:0] ARM_GUARD_RELOAD = 2'd2;

endpackage

// File: rtl/bomb_game_controller_if.sv
// bomb_game_controller_if: game-side bus between the controller and the
// start button / puzzles / countdown datapath.
//   start, puzzle_done, strike, value_*   : into the controller
//   game_state, solved_mask, strike_count,
//   defuse_pulse, explode_pulse           : out of the controller
// master = environment side, slave = controller side.
interface bomb_game_controller_if #(
  parameter int NUM_PUZZLES = 4
);
  logic                   start;
  logic [NUM_PUZZLES-1:0] puzzle_done;
  logic [NUM_PUZZLES-1:0] strike;
  logic [3:0]             value_three;
  logic [3:0]             value_two;
  logic [3:0]             value_one;
  logic [7:0]             game_state;
  logic [NUM_PUZZLES-1:0] solved_mask;
  logic [1:0]             strike_count;
  logic                   defuse_pulse;
  logic                   explode_pulse;

  modport master (
    output start, puzzle_done, strike, value_three, value_two, value_one,
    input  game_state, solved_mask, strike_count, defuse_pulse, explode_pulse
  );

  modport slave (
    input  start, puzzle_done, strike, value_three, value_two, value_one,
    output game_state, solved_mask, strike_count, defuse_pulse, explode_pulse
  );
endinterface

// File: rtl/strike_counter.sv
// strike_counter: combinational strike accumulation.
//   strike_i     : strike pulses already masked by the solved flags
//   count_i      : registered strike count
//   count_o      : count plus popcount of strike_i, saturated at MAX_STRIKES
//   strike_out_o : count plus this cycle's strikes reaches MAX_STRIKES
module strike_counter #(
  parameter int NUM_PUZZLES = 4,
  parameter int MAX_STRIKES = 3
) (
  input  logic [NUM_PUZZLES-1:0] strike_i,
  input  logic [1:0]             count_i,
  output logic [1:0]             count_o,
  output logic                   strike_out_o
);
  localparam logic [4:0] MAX_W = 5'(MAX_STRIKES);

  logic [4:0] pop;
  logic [4:0] sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_PUZZLES; i++) begin
      pop = pop + {4'b0, strike_i[i]};
    end
    sum          = {3'b0, count_i} + pop;
    strike_out_o = (sum >= MAX_W);
    count_o      = strike_out_o ? MAX_W[1:0] : sum[1:0];
  end
endmodule

// File: rtl/bomb_game_controller.sv
// bomb_game_controller: top-level game sequencer.
//   clk   : 50 MHz system clock
//   reset : asynchronous, active-low
//   bus   : slave side of bomb_game_controller_if (start button, puzzle
//           status/strikes, countdown digits in; game_state bus, solved
//           flags, strike count and entry pulses out). All outputs registered.
module bomb_game_controller
  import bomb_pkg::*;
#(
  parameter int NUM_PUZZLES = 4,
  parameter int MAX_STRIKES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  bomb_game_controller_if.slave  bus
);
  game_state_e            state_q,   state_d;
  logic [1:0]             guard_q,   guard_d;
  logic [NUM_PUZZLES-1:0] solved_q,  solved_d;
  logic [1:0]             strike_q,  strike_d;
  logic                   defuse_q,  defuse_d;
  logic                   explode_q, explode_d;

  logic [1:0] strike_next;
  logic       strike_out;
  logic       timeout;
  logic       all_solved;

  // Strikes from an already-solved puzzle are not counted.
  strike_counter #(
    .NUM_PUZZLES (NUM_PUZZLES),
    .MAX_STRIKES (MAX_STRIKES)
  ) u_strike_counter (
    .strike_i     (bus.strike & ~solved_q),
    .count_i      (strike_q),
    .count_o      (strike_next),
    .strike_out_o (strike_out)
  );

  assign timeout    = (guard_q == 2'd0) &&
                      ({bus.value_three, bus.value_two, bus.value_one} == 12'h000);
  // A puzzle finishing this very cycle counts towards the defuse.
  assign all_solved = &(solved_q | bus.puzzle_done);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      guard_q   <= '0;
      solved_q  <= '0;
      strike_q  <= '0;
      defuse_q  <= 1'b0;
      explode_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      guard_q   <= guard_d;
      solved_q  <= solved_d;
      strike_q  <= strike_d;
      defuse_q  <= defuse_d;
      explode_q <= explode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_ARMED;
      // Explosion outranks a simultaneous defuse.
      ST_ARMED: begin
        if (timeout || strike_out) state_d = ST_EXPLODED;
        else if (all_solved)       state_d = ST_DEFUSED;
      end
      ST_DEFUSED, ST_EXPLODED: if (bus.start) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    guard_d  = guard_q;
    solved_d = solved_q;
    strike_d = strike_q;
    case (state_q)
      ST_IDLE: begin
        solved_d = '0;
        strike_d = '0;
        guard_d  = bus.start ? ARM_GUARD_RELOAD : 2'd0;
      end
      ST_ARMED: begin
        if (guard_q != 2'd0) guard_d = guard_q - 2'd1;
        solved_d = solved_q | bus.puzzle_done;
        strike_d = strike_next;
      end
      // Terminal states hold the round's results for display.
      default: ;
    endcase
    defuse_d  = (state_d == ST_DEFUSED)  && (state_q != ST_DEFUSED);
    explode_d = (state_d == ST_EXPLODED) && (state_q != ST_EXPLODED);
  end

  assign bus.game_state    = state_q;
  assign bus.solved_mask   = solved_q;
  assign bus.strike_count  = strike_q;
  assign bus.defuse_pulse  = defuse_q;
  assign bus.explode_pulse = explode_q;
endmodule

// File: tb/tb_bomb_game_controller.sv
// Directed testbench for bomb_game_controller (NUM_PUZZLES=4, MAX_STRIKES=3).
module tb_bomb_game_controller;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  bomb_game_controller_if #(.NUM_PUZZLES(4)) bus ();

  bomb_game_controller #(
    .NUM_PUZZLES (4),
    .MAX_STRIKES (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0; bus.puzzle_done = 4'h0; bus.strike = 4'h0;
    bus.value_three = 4'd2; bus.value_two = 4'd0; bus.value_one = 4'd0;
    tick(); tick();
    tests++; if (bus.game_state !== 8'h00) begin fails++; $display("FAIL reset_state got %h want 00", bus.game_state); end
    tests++; if (bus.solved_mask !== 4'h0) begin fails++; $display("FAIL reset_solved got %h want 0", bus.solved_mask); end
    tests++; if (bus.strike_count !== 2'd0) begin fails++; $display("FAIL reset_strikes got %0d want 0", bus.strike_count); end
    tests++; if ({bus.defuse_pulse, bus.explode_pulse} !== 2'b00) begin fails++; $display("FAIL reset_pulses got %b want 00", {bus.defuse_pulse, bus.explode_pulse}); end
    reset = 1'b1;
    tick();
    tests++; if (bus.game_state !== 8'h00) begin fails++; $display("FAIL idle_hold got %h want 00", bus.game_state); end
  endtask

  task automatic test_defuse();
    pulse_start();
    tests++; if (bus.game_state !== 8'h10) begin fails++; $display("FAIL defuse_armed got %h want 10", bus.game_state); end
    tick();
    bus.puzzle_done = 4'hF;
    tick();
    tests++; if (bus.game_state !== 8'h20) begin fails++; $display("FAIL defuse_state got %h want 20", bus.game_state); end
    tests++; if (bus.defuse_pulse !== 1'b1) begin fails++; $display("FAIL defuse_pulse_on got %b want 1", bus.defuse_pulse); end
    tests++; if (bus.solved_mask !== 4'hF) begin fails++; $display("FAIL defuse_solved got %h want F", bus.solved_mask); end
    tick();
    tests++; if (bus.defuse_pulse !== 1'b0) begin fails++; $display("FAIL defuse_pulse_off got %b want 0", bus.defuse_pulse); end
    tests++; if (bus.game_state !== 8'h20) begin fails++; $display("FAIL defuse_hold got %h want 20", bus.game_state); end
    bus.puzzle_done = 4'h0;
    pulse_start();
    tests++; if (bus.game_state !== 8'h00) begin fails++; $display("FAIL defuse_to_idle got %h want 00", bus.game_state); end
    tick();
    tests++; if (bus.solved_mask !== 4'h0) begin fails++; $display("FAIL idle_clear_solved got %h want 0", bus.solved_mask); end
  endtask

  task automatic test_timeout_guard();
    bus.value_three = 4'd0; bus.value_two = 4'd0; bus.value_one = 4'd0;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      tests++; if (bus.game_state !== 8'h10) begin fails++; $display("FAIL guard_cycle%0d got %h want 10", i, bus.game_state); end
      tests++; if (bus.explode_pulse !== 1'b0) begin fails++; $display("FAIL guard_pulse%0d got %b want 0", i, bus.explode_pulse); end
      tick();
    end
    tests++; if (bus.game_state !== 8'h30) begin fails++; $display("FAIL timeout_state got %h want 30", bus.game_state); end
    tests++; if (bus.explode_pulse !== 1'b1) begin fails++; $display("FAIL timeout_pulse got %b want 1", bus.explode_pulse); end
    tick();
    tests++; if (bus.explode_pulse !== 1'b0) begin fails++; $display("FAIL timeout_pulse_off got %b want 0", bus.explode_pulse); end
    bus.value_three = 4'd2;
    pulse_start();
    tick();
  endtask

  task automatic test_strikes();
    pulse_start();
    bus.strike = 4'b0001; tick();
    tests++; if (bus.strike_count !== 2'd1) begin fails++; $display("FAIL strike1 got %0d want 1", bus.strike_count); end
    bus.strike = 4'b0010; tick();
    tests++; if (bus.strike_count !== 2'd2) begin fails++; $display("FAIL strike2 got %0d want 2", bus.strike_count); end
    tests++; if (bus.game_state !== 8'h10) begin fails++; $display("FAIL strike2_state got %h want 10", bus.game_state); end
    bus.strike = 4'b0100; tick();
    bus.strike = 4'b0000;
    tests++; if (bus.strike_count !== 2'd3) begin fails++; $display("FAIL strike3 got %0d want 3", bus.strike_count); end
    tests++; if (bus.game_state !== 8'h30) begin fails++; $display("FAIL strikeout_state got %h want 30", bus.game_state); end
    tests++; if (bus.explode_pulse !== 1'b1) begin fails++; $display("FAIL strikeout_pulse got %b want 1", bus.explode_pulse); end
    bus.strike = 4'b0001; tick();
    bus.strike = 4'b0000;
    tests++; if (bus.strike_count !== 2'd3) begin fails++; $display("FAIL frozen_strikes got %0d want 3", bus.strike_count); end
    pulse_start();
    tick();
    tests++; if (bus.strike_count !== 2'd0) begin fails++; $display("FAIL idle_clear_strikes got %0d want 0", bus.strike_count); end
  endtask

  task automatic test_masked_and_priority();
    pulse_start();
    bus.puzzle_done = 4'b0010; tick();
    tests++; if (bus.solved_mask !== 4'b0010) begin fails++; $display("FAIL solved_p1 got %b want 0010", bus.solved_mask); end
    bus.strike = 4'b0010; tick();
    bus.strike = 4'b0000;
    tests++; if (bus.strike_count !== 2'd0) begin fails++; $display("FAIL masked_strike got %0d want 0", bus.strike_count); end
    bus.strike = 4'b0001; tick();
    bus.strike = 4'b0001; tick();
    tests++; if (bus.strike_count !== 2'd2) begin fails++; $display("FAIL pre_final_strikes got %0d want 2", bus.strike_count); end
    bus.strike = 4'b0011; bus.puzzle_done = 4'hF; tick();
    bus.strike = 4'b0000;
    tests++; if (bus.game_state !== 8'h30) begin fails++; $display("FAIL priority_state got %h want 30", bus.game_state); end
    tests++; if (bus.strike_count !== 2'd3) begin fails++; $display("FAIL priority_strikes got %0d want 3", bus.strike_count); end
    tests++; if (bus.defuse_pulse !== 1'b0) begin fails++; $display("FAIL priority_no_defuse got %b want 0", bus.defuse_pulse); end
    bus.puzzle_done = 4'h0;
    pulse_start();
    tick();
  endtask

  task automatic test_async_reset_and_start();
    pulse_start();
    bus.strike = 4'b0001; tick();
    bus.strike = 4'b0010; tick();
    bus.strike = 4'b0000;
    pulse_start();
    tests++; if (bus.game_state !== 8'h10) begin fails++; $display("FAIL start_in_armed got %h want 10", bus.game_state); end
    tests++; if (bus.strike_count !== 2'd2) begin fails++; $display("FAIL pre_reset_strikes got %0d want 2", bus.strike_count); end
    #2 reset = 1'b0;
    #1;
    tests++; if (bus.game_state !== 8'h00) begin fails++; $display("FAIL async_reset_state got %h want 00", bus.game_state); end
    tests++; if (bus.strike_count !== 2'd0) begin fails++; $display("FAIL async_reset_strikes got %0d want 0", bus.strike_count); end
    tick();
    reset = 1'b1;
    tick();
    pulse_start();
    bus.strike = 4'b0111; tick();
    bus.strike = 4'b0000;
    tests++; if (bus.game_state !== 8'h30) begin fails++; $display("FAIL multi_strike_state got %h want 30", bus.game_state); end
    pulse_start();
    tests++; if (bus.game_state !== 8'h00) begin fails++; $display("FAIL exploded_to_idle got %h want 00", bus.game_state); end
    tick();
    tests++; if (bus.game_state !== 8'h00) begin fails++; $display("FAIL idle_needs_start got %h want 00", bus.game_state); end
    pulse_start();
    tests++; if (bus.game_state !== 8'h10) begin fails++; $display("FAIL rearm got %h want 10", bus.game_state); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_defuse();
    test_timeout_guard();
    test_strikes();
    test_masked_and_priority();
    test_async_reset_and_start();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bomb_game_controller.md
# bomb_game_controller

Top-level game sequencer for the bomb-defusal game. Owns the shared `game_state` bus that the countdown timer and all puzzle modules consume, and moves the game through idle, armed, defused and exploded. Tracks which puzzles are solved, counts strikes, and watches the countdown digits for timeout. Sits between the debounced start button and puzzle modules on one side and the countdown/display datapath on the other.

## Interface
Parameters:
- `NUM_PUZZLES`, default 4: number of puzzle modules; range 1..8.
- `MAX_STRIKES`, default 3: strike count that causes an explosion; range 1..3.

Ports:
- `clk`, in, 1: on-board 50 MHz clock. One clock domain.
- `reset`, in, 1: asynchronous, active-low. Already decided.
- `start`, in, 1: debounced start button, single-cycle high pulse.
- `puzzle_done`, in, NUM_PUZZLES: level from each puzzle, high when that puzzle is solved.
- `strike`, in, NUM_PUZZLES: single-cycle pulse from each puzzle on a wrong action.
- `value_three`, `value_two`, `value_one`, in, 4 each: countdown BCD digits (hundreds, tens, ones).
- `game_state`, out, 8: 8'h00 IDLE, 8'h10 ARMED, 8'h20 DEFUSED, 8'h30 EXPLODED.
- `solved_mask`, out, NUM_PUZZLES: sticky solved flags.
- `strike_count`, out, 2: strikes taken this round. Saturates at MAX_STRIKES.
- `defuse_pulse`, out, 1: high for one cycle on entry to DEFUSED.
- `explode_pulse`, out, 1: high for one cycle on entry to EXPLODED.

## Operation
- Reset values: `game_state` = 8'h00, `solved_mask` = 0, `strike_count` = 0, both pulses = 0, `guard` = 0.
- **IDLE**
  - On `start`: go to ARMED.
  - Clear `solved_mask` and `strike_count`.
  - Load the 2-bit arm guard counter with 2.
- **ARMED**
  - Arm guard:
    - `guard` decrements each cycle while it is nonzero.
    - The timeout check is ignored while `guard` ≠ 0.
    - Reason: the countdown reloads to 200 only on the edge after it sees 8'h10, so stale 000 digits may be present for the first cycle.
  - Solved flags: `solved_mask[i]` is set when `puzzle_done[i]` is high. Once set, it never clears until the next return to IDLE.
  - Strikes:
    - `strike[i]` counts only while `solved_mask[i]` = 0.
    - Several strike pulses in the same cycle each count.
    - The increment is the popcount of the masked `strike` vector.
    - The sum saturates at MAX_STRIKES.
  - Timeout: `guard` = 0 and digits == 0,0,0.
  - Strike-out: registered `strike_count` plus this cycle's increment ≥ MAX_STRIKES.
  - All-solved: (`solved_mask` | `puzzle_done`) is all ones.
  - Priority when several hold in the same cycle: timeout, then strike-out (both go to EXPLODED), then all-solved (goes to DEFUSED).
  - `start` is ignored while ARMED.
- **DEFUSED / EXPLODED**
  - Terminal states.
  - `solved_mask` and `strike_count` are frozen for display.
  - `strike` and `puzzle_done` are ignored.
  - `start` returns the game to IDLE. A second `start` is needed to arm again.
- Asynchronous reset mid-game forces IDLE immediately. The countdown sees 8'h00 and stays in its init state.

## Timing
- All outputs are registered.
- A qualifying input at edge N is reflected in `game_state` after edge N, i.e. one cycle of latency.
- `defuse_pulse` and `explode_pulse` assert in the same cycle that `game_state` first shows 8'h20 or 8'h30, and deassert the next cycle.
- `strike_count` updates in the same cycle as the strike pulse is registered. When the last strike causes EXPLODED, `strike_count` shows MAX_STRIKES in the first EXPLODED cycle.
- The earliest possible timeout is the third cycle after entering ARMED.

## Structure
- Shared package (`bomb_pkg`) holds:
  - Game-state encodings: IDLE = 8'h00, ARMED = 8'h10, DEFUSED = 8'h20, EXPLODED = 8'h30. Countdown and puzzle modules compare against these.
  - Arm guard reload constant: 2.
- One natural sub-module: `strike_counter`. It takes the masked strike vector, does the popcount and the saturating add, and produces the strike-out flag.
- The state machine and solved-mask logic stay in the top module.

## Test plan
- Reset, `start`, then `puzzle_done` = 4'b1111 two cycles later → `game_state` goes 00 → 10 → 20. `defuse_pulse` is high for exactly 1 cycle. `solved_mask` = 4'hF.
- Armed, digits held at 0,0,0 from the first ARMED cycle → no explosion during the guard window. EXPLODED on the third ARMED cycle, with `explode_pulse`.
- Strikes on puzzles 0, 1, 2 in separate cycles (MAX_STRIKES = 3) → `strike_count` goes 1, 2, 3. EXPLODED on the cycle after the third strike.
- Puzzle 1 solved, then `strike[1]` pulses → `strike_count` stays 0.
- `strike` = 4'b0011 with `strike_count` = 2, in the same cycle as the final `puzzle_done` → EXPLODED, not DEFUSED. `strike_count` = 3.
- Async `reset` low mid-ARMED with `strike_count` = 2 → immediately 8'h00 and counts cleared. `start` while ARMED is ignored. `start` in EXPLODED → IDLE, and a second `start` → ARMED.
